// File: rtl/logic_ops_arbiter.sv
// ----------------------------------------------------------------------------
// logic_ops_arbiter
//
// Shares one LogicOps unit among NUM_REQ requesters. A round-robin arbiter picks
// one valid request per cycle and loads its operands into the S1 operand
// register, which drives the LogicOps inputs. The LogicOps result and flags are
// captured one cycle later into the S2 response register along with the ID of
// the requester. Responses leave in grant order on one valid/ready channel.
//
// Ports
//   clk, rstN        clock (rising edge), asynchronous active-low reset
//   reqValid         per-requester request valid
//   reqReady         per-requester grant, at most one bit set
//   reqOpA, reqOpB   per-requester 32-bit operands, requester i at [32*i +: 32]
//   reqCIn           per-requester carry-in
//   reqAluOp         per-requester opcode, requester i at [OP_W*i +: OP_W]
//   luOpA, luOpB     registered operands to LogicOps
//   luCIn, luAluOp   registered carry-in and opcode to LogicOps
//   luOut, luFlags   combinational result and flags from LogicOps
//   rspValid         response valid
//   rspReady         response consumer ready
//   rspData          result word
//   rspFlags         {dbz, z, n, v, evenPar, oddPar, c}
//   rspId            index of the requester that issued this result
//   busy             an operation is held in S1 or S2
// ----------------------------------------------------------------------------
module logic_ops_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_REQ-1:0]        reqValid,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic [NUM_REQ*32-1:0]     reqOpA,
    input  logic [NUM_REQ*32-1:0]     reqOpB,
    input  logic [NUM_REQ-1:0]        reqCIn,
    input  logic [NUM_REQ*OP_W-1:0]   reqAluOp,
    output logic [31:0]               luOpA,
    output logic [31:0]               luOpB,
    output logic                      luCIn,
    output logic [OP_W-1:0]           luAluOp,
    input  logic [31:0]               luOut,
    input  logic [6:0]                luFlags,
    output logic                      rspValid,
    input  logic                      rspReady,
    output logic [31:0]               rspData,
    output logic [6:0]                rspFlags,
    output logic [ID_W-1:0]           rspId,
    output logic                      busy
);

    localparam int DATA_W = 32;

    logic              vld_p1;
    logic [ID_W-1:0]   id_p1;
    logic [ID_W-1:0]   rrPtr;
    logic              advance2;
    logic              accept1;
    logic              grantValid;
    logic [ID_W-1:0]   grantIdx;
    logic [DATA_W-1:0] selOpA;
    logic [DATA_W-1:0] selOpB;
    logic              selCIn;
    logic [OP_W-1:0]   selAluOp;

    // base + offs, wrapped into 0..NUM_REQ-1 (offs is at most NUM_REQ-1)
    function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    // S2 moves whenever S1 has data and the response slot is free or draining;
    // S1 can take a new request when empty or when it is moving into S2.
    assign advance2 = vld_p1 & (~rspValid | rspReady);
    assign accept1  = ~vld_p1 | advance2;
    assign busy     = vld_p1 | rspValid;

    // Round-robin search starting at rrPtr; reqReady is forced low in reset.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantValid && reqValid[wrapAdd(rrPtr, i)]) begin
                grantValid = 1'b1;
                grantIdx   = wrapAdd(rrPtr, i);
            end
        end
        if (!(accept1 && rstN)) begin
            grantValid = 1'b0;
        end
    end

    always_comb begin
        reqReady = '0;
        if (grantValid) begin
            reqReady[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        selOpA   = '0;
        selOpB   = '0;
        selCIn   = 1'b0;
        selAluOp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                selOpA   = reqOpA[DATA_W*i +: DATA_W];
                selOpB   = reqOpB[DATA_W*i +: DATA_W];
                selCIn   = reqCIn[i];
                selAluOp = reqAluOp[OP_W*i +: OP_W];
            end
        end
    end

    // Control: S1/S2 valid bits and round-robin pointer
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_p1   <= 1'b0;
            rrPtr    <= '0;
            rspValid <= 1'b0;
        end else begin
            if (grantValid) begin
                vld_p1 <= 1'b1;
                rrPtr  <= wrapAdd(grantIdx, 1);
            end else if (advance2) begin
                vld_p1 <= 1'b0;
            end
            if (advance2) begin
                rspValid <= 1'b1;
            end else if (rspReady) begin
                rspValid <= 1'b0;
            end
        end
    end

    // Datapath: S1 operand register (request -> LogicOps inputs),
    // S2 response register (LogicOps outputs -> rsp*)
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            luOpA    <= '0;
            luOpB    <= '0;
            luCIn    <= 1'b0;
            luAluOp  <= '0;
            id_p1    <= '0;
            rspData  <= '0;
            rspFlags <= '0;
            rspId    <= '0;
        end else begin
            if (grantValid) begin
                luOpA   <= selOpA;
                luOpB   <= selOpB;
                luCIn   <= selCIn;
                luAluOp <= selAluOp;
                id_p1   <= grantIdx;
            end
            if (advance2) begin
                rspData  <= luOut;
                rspFlags <= luFlags;
                rspId    <= id_p1;
            end
        end
    end

endmodule

// File: tb/tb_logic_ops_arbiter.sv
module tb_logic_ops_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'h1;
    localparam logic [OP_W-1:0] ALU_OR  = 4'h2;
    localparam logic [OP_W-1:0] ALU_XOR = 4'h3;
    localparam logic [OP_W-1:0] ALU_BAD = 4'hF;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic            cin;
    } reqItem_t;

    typedef struct {
        logic [31:0]     data;
        logic [6:0]      flags;
        logic [ID_W-1:0] id;
    } expItem_t;

    typedef struct {
        int unsigned     r;
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic            cin;
        logic [31:0]     expData;
        logic [6:0]      expFlags;
    } vec_t;

    logic                    clk;
    logic                    rstN;
    logic [NUM_REQ-1:0]      reqValid;
    logic [NUM_REQ-1:0]      reqReady;
    logic [NUM_REQ*32-1:0]   reqOpA;
    logic [NUM_REQ*32-1:0]   reqOpB;
    logic [NUM_REQ-1:0]      reqCIn;
    logic [NUM_REQ*OP_W-1:0] reqAluOp;
    logic [31:0]             luOpA;
    logic [31:0]             luOpB;
    logic                    luCIn;
    logic [OP_W-1:0]         luAluOp;
    logic [31:0]             luOut;
    logic [6:0]              luFlags;
    logic                    rspValid;
    logic                    rspReady;
    logic [31:0]             rspData;
    logic [6:0]              rspFlags;
    logic [ID_W-1:0]         rspId;
    logic                    busy;

    logic_ops_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .OP_W(OP_W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqOpA   (reqOpA),
        .reqOpB   (reqOpB),
        .reqCIn   (reqCIn),
        .reqAluOp (reqAluOp),
        .luOpA    (luOpA),
        .luOpB    (luOpB),
        .luCIn    (luCIn),
        .luAluOp  (luAluOp),
        .luOut    (luOut),
        .luFlags  (luFlags),
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspData  (rspData),
        .rspFlags (rspFlags),
        .rspId    (rspId),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for LogicOps
    function automatic logic [31:0] lopsOut(input logic [OP_W-1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [6:0] lopsFlags(input logic [31:0] r, input logic c);
        return {1'b0, (r == 32'h0), r[31], 1'b0, ~^r, ^r, c};
    endfunction

    always_comb begin
        luOut   = lopsOut(luAluOp, luOpA, luOpB);
        luFlags = lopsFlags(luOut, luCIn);
    end

    reqItem_t reqMem [NUM_REQ][8];
    int       reqCnt [NUM_REQ];
    int       reqPos [NUM_REQ];
    expItem_t expQ[$];
    int       grantLog[$];
    int       nChecks;
    int       nFails;
    int       cycCount;
    int       lastPopCyc;
    int       nHs;
    logic     rdyNext;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int pendingReqs();
        int s = 0;
        for (int r = 0; r < NUM_REQ; r++) s += reqCnt[r] - reqPos[r];
        return s;
    endfunction

    task automatic clearReqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            reqCnt[r] = 0;
            reqPos[r] = 0;
        end
    endtask

    task automatic addReq(input int r, input logic [OP_W-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
        reqMem[r][reqCnt[r]] = '{op, a, b, cin};
        reqCnt[r]++;
    endtask

    task automatic pushExp(input int r, input reqItem_t it);
        logic [31:0] d;
        d = lopsOut(it.op, it.a, it.b);
        expQ.push_back('{d, lopsFlags(d, it.cin), ID_W'(r)});
    endtask

    // One clock: drive after the rising edge, observe at the falling edge.
    task automatic cycle();
        expItem_t e;
        @(posedge clk);
        #1;
        cycCount++;
        rspReady = rdyNext;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (reqPos[r] < reqCnt[r]) begin
                reqValid[r]              = 1'b1;
                reqOpA[32*r +: 32]       = reqMem[r][reqPos[r]].a;
                reqOpB[32*r +: 32]       = reqMem[r][reqPos[r]].b;
                reqCIn[r]                = reqMem[r][reqPos[r]].cin;
                reqAluOp[OP_W*r +: OP_W] = reqMem[r][reqPos[r]].op;
            end else begin
                reqValid[r] = 1'b0;
            end
        end
        @(negedge clk);
        check("onehot0", 64'($countones(reqReady) <= 1), 64'(1));
        if (rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL rsp_unexpected: got id %0d data 0x%0h, required no response",
                         rspId, rspData);
            end else begin
                e = expQ.pop_front();
                check("rsp", {23'b0, rspId, rspFlags, rspData}, {23'b0, e.id, e.flags, e.data});
                lastPopCyc = cycCount;
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (reqValid[r] && reqReady[r]) begin
                reqPos[r]++;
                grantLog.push_back(r);
                nHs++;
            end
        end
    endtask

    task automatic drain(input int maxCyc);
        int n = 0;
        while ((expQ.size() != 0 || pendingReqs() != 0) && n < maxCyc) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        check("drain_empty", 64'(expQ.size()), 64'(0));
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_rspValid"}, 64'(rspValid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_reqReady"}, 64'(reqReady), 64'(0));
        check({tag, "_luOps"}, {luOpB, luOpA}, 64'(0));
        check({tag, "_luCtl"}, 64'({luCIn, luAluOp}), 64'(0));
        check({tag, "_rsp"}, 64'({rspId, rspFlags, rspData}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t     vecs [8];
        reqItem_t it;
        reqItem_t w3 [2];
        reqItem_t w1 [2];
        int       start;
        int       hs0;
        int       g0;
        int       bad;
        logic [63:0] held;

        nChecks = 0; nFails = 0; cycCount = 0; lastPopCyc = -1; nHs = 0;
        rdyNext = 1'b1;
        rstN = 1'b0;
        reqValid = '1; reqOpA = '0; reqOpB = '0; reqCIn = '0; reqAluOp = '0;
        rspReady = 1'b1;
        clearReqs();

        // Reset: grants suppressed even with every request asserted
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reqValid = '0;
        rstN = 1'b1;

        //        r  op       opA           opB           cin   data          flags
        vecs[0] = '{0, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 7'h14};
        vecs[1] = '{2, ALU_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 7'h24};
        vecs[2] = '{1, ALU_OR,  32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003, 7'h05};
        vecs[3] = '{3, ALU_AND, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'h8000_0001, 7'h14};
        vecs[4] = '{1, ALU_XOR, 32'h0000_0000, 32'h0000_0007, 1'b1, 32'h0000_0007, 7'h03};
        vecs[5] = '{0, ALU_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 7'h24};
        vecs[6] = '{2, ALU_AND, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, 32'h000F_000F, 7'h04};
        vecs[7] = '{3, ALU_OR,  32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 7'h13};

        for (int v = 0; v < 8; v++) begin
            clearReqs();
            addReq(int'(vecs[v].r), vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cin);
            expQ.push_back('{vecs[v].expData, vecs[v].expFlags, ID_W'(vecs[v].r)});
            start = cycCount;
            lastPopCyc = -1;
            drain(20);
            check("single_latency", 64'(lastPopCyc - start), 64'(3));
        end

        // Full contention from rrPtr=0: grants 0,1,2,3,0,1,2,3, one result per cycle
        clearReqs();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                it = '{OP_W'(1 + (r + k) % 3), $urandom, $urandom, 1'(r)};
                addReq(r, it.op, it.a, it.b, it.cin);
                pushExp(r, it);
            end
        end
        start = cycCount;
        drain(40);
        check("contention_thruput", 64'(lastPopCyc - start), 64'(10));

        // Back-pressure: consumer stalls for 5 cycles with all requesters pending
        clearReqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            it = '{ALU_XOR, $urandom, $urandom, 1'b0};
            addReq(r, it.op, it.a, it.b, it.cin);
            pushExp(r, it);
        end
        rdyNext = 1'b0;
        hs0 = nHs;
        cycle();
        cycle();
        cycle();
        check("bp_valid", 64'(rspValid), 64'(1));
        held = {23'b0, rspId, rspFlags, rspData};
        for (int c = 0; c < 2; c++) begin
            cycle();
            check("bp_stable", {23'b0, rspId, rspFlags, rspData}, held);
            check("bp_valid_hold", 64'(rspValid), 64'(1));
        end
        check("bp_accepted", 64'(nHs - hs0), 64'(2));
        check("bp_ready_low", 64'(reqReady), 64'(0));
        rdyNext = 1'b1;
        drain(30);

        // Wrap and skip: move rrPtr to 2, then only requesters 1 and 3 compete
        clearReqs();
        it = '{ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0};
        addReq(1, it.op, it.a, it.b, it.cin);
        pushExp(1, it);
        drain(20);
        clearReqs();
        for (int k = 0; k < 2; k++) begin
            w3[k] = '{ALU_AND, $urandom, $urandom, 1'b1};
            w1[k] = '{ALU_XOR, $urandom, $urandom, 1'b0};
            addReq(3, w3[k].op, w3[k].a, w3[k].b, w3[k].cin);
            addReq(1, w1[k].op, w1[k].a, w1[k].b, w1[k].cin);
        end
        for (int k = 0; k < 2; k++) begin
            pushExp(3, w3[k]);
            pushExp(1, w1[k]);
        end
        g0 = grantLog.size();
        drain(30);
        bad = 0;
        for (int i = g0; i < grantLog.size(); i++) begin
            if (grantLog[i] == 0 || grantLog[i] == 2) bad++;
        end
        check("wrap_skip", 64'(bad), 64'(0));
        check("wrap_first", 64'(grantLog.size() > g0 ? grantLog[g0] : 99), 64'(3));

        // Reset mid-flight with S1 and S2 both holding work
        clearReqs();
        addReq(1, ALU_AND, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
        addReq(2, ALU_OR,  32'h0102_0304, 32'h1000_0000, 1'b1);
        rdyNext = 1'b0;
        repeat (3) cycle();
        check("busy_full", 64'(busy), 64'(1));
        check("full_rspValid", 64'(rspValid), 64'(1));
        rstN = 1'b0;
        reqValid = '0;
        #1;
        checkResetState("midreset");
        clearReqs();
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            it = '{ALU_AND, $urandom, $urandom, 1'b0};
            addReq(r, it.op, it.a, it.b, it.cin);
            pushExp(r, it);
        end
        rdyNext = 1'b1;
        g0 = grantLog.size();
        drain(30);
        check("post_reset_grant", 64'(grantLog.size() > g0 ? grantLog[g0] : 99), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
